// File: rtl/pingpong_pkg.sv
// Shared definitions for the write-side ping-pong bank demultiplexer.
//   bank_state_e : per-bank fill state (FREE, FILL, FULL)
//   cnt_width()  : width of the per-block word counter for a given BLOCK_LEN
package pingpong_pkg;

  typedef enum logic [1:0] {
    BANK_FREE = 2'd0,
    BANK_FILL = 2'd1,
    BANK_FULL = 2'd2
  } bank_state_e;

  // Counter width for BLOCK_LEN words per bank; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pingpong_demux2_bank_out_stage.sv
// One-entry registered output stage for a single bank-write channel.
//   clk, rst   : clock, synchronous active-high reset
//   load       : capture load_data and mark the entry valid
//   load_data  : word to capture
//   ready      : downstream bank accepts the held word
//   data/valid : registered bank-write channel
//   empty      : no word held
// A load in the same cycle as a drain keeps valid high and replaces the data.
module bank_out_stage #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             empty
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

  assign empty = ~valid;

endmodule

// File: rtl/pingpong_demux2.sv
// Write-side ping-pong demultiplexer: steers one valid/ready word stream into
// two bank-write channels, BLOCK_LEN words per bank, alternating banks.
//   clk, rst              : clock, synchronous active-high reset
//   in_data/valid/ready   : input word stream
//   out0_*, out1_*        : bank-write channels (registered, one entry each)
//   release_req[b]        : consumer releases full bank b ("release" is a
//                           reserved word, hence the suffix)
//   active_bank           : bank currently being filled
//   bank_full[b]          : bank b is FULL
//   fill_done             : pulses the cycle after a bank's last word is taken
//   word_cnt              : words accepted into the active bank so far
module pingpong_demux2
  import pingpong_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned BLOCK_LEN = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [WIDTH-1:0]                  in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [WIDTH-1:0]                  out0_data,
  output logic                              out0_valid,
  input  logic                              out0_ready,
  output logic [WIDTH-1:0]                  out1_data,
  output logic                              out1_valid,
  input  logic                              out1_ready,
  input  logic [1:0]                        release_req,
  output logic                              active_bank,
  output logic [1:0]                        bank_full,
  output logic                              fill_done,
  output logic [cnt_width(BLOCK_LEN)-1:0]   word_cnt
);

  localparam int unsigned   CW       = cnt_width(BLOCK_LEN);
  localparam logic [CW-1:0] LAST_IDX = CW'(BLOCK_LEN - 1);

  bank_state_e st0;
  bank_state_e st1;
  logic        empty0;
  logic        empty1;
  logic        act_full;
  logic        act_room;
  logic        accept;
  logic        last_word;
  logic        load0;
  logic        load1;

  // in_ready depends only on registered state and the active bank's ready,
  // never on in_valid.
  always_comb begin
    act_full = active_bank ? (st1 == BANK_FULL) : (st0 == BANK_FULL);
    act_room = active_bank ? (empty1 | out1_ready) : (empty0 | out0_ready);
    in_ready = ~rst & ~act_full & act_room;
  end

  assign accept    = in_valid & in_ready;
  assign last_word = (word_cnt == LAST_IDX);
  assign load0     = accept & ~active_bank;
  assign load1     = accept & active_bank;

  bank_out_stage #(.WIDTH(WIDTH)) u_out0 (
    .clk       (clk),
    .rst       (rst),
    .load      (load0),
    .load_data (in_data),
    .ready     (out0_ready),
    .data      (out0_data),
    .valid     (out0_valid),
    .empty     (empty0)
  );

  bank_out_stage #(.WIDTH(WIDTH)) u_out1 (
    .clk       (clk),
    .rst       (rst),
    .load      (load1),
    .load_data (in_data),
    .ready     (out1_ready),
    .data      (out1_data),
    .valid     (out1_valid),
    .empty     (empty1)
  );

  // Bank state machines, word counter and active bank toggle.
  // A release only acts on a FULL bank whose output register is empty, so a
  // release coinciding with the last-word accept is ignored (bank was FILL).
  always_ff @(posedge clk) begin
    if (rst) begin
      st0         <= BANK_FREE;
      st1         <= BANK_FREE;
      word_cnt    <= '0;
      active_bank <= 1'b0;
      fill_done   <= 1'b0;
    end else begin
      fill_done <= accept & last_word;

      unique case (st0)
        BANK_FREE: if (load0) st0 <= last_word ? BANK_FULL : BANK_FILL;
        BANK_FILL: if (load0 && last_word) st0 <= BANK_FULL;
        BANK_FULL: if (release_req[0] && empty0) st0 <= BANK_FREE;
        default:   st0 <= BANK_FREE;
      endcase

      unique case (st1)
        BANK_FREE: if (load1) st1 <= last_word ? BANK_FULL : BANK_FILL;
        BANK_FILL: if (load1 && last_word) st1 <= BANK_FULL;
        BANK_FULL: if (release_req[1] && empty1) st1 <= BANK_FREE;
        default:   st1 <= BANK_FREE;
      endcase

      if (accept) begin
        if (last_word) begin
          word_cnt    <= '0;
          active_bank <= ~active_bank;
        end else begin
          word_cnt <= word_cnt + 1'b1;
        end
      end
    end
  end

  assign bank_full = {st1 == BANK_FULL, st0 == BANK_FULL};

endmodule

// File: tb/tb_pingpong_demux2.sv
module tb_pingpong_demux2;

  localparam int unsigned W = 16;
  localparam int unsigned L = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  out0_data;
  logic          out0_valid;
  logic          out0_ready;
  logic [W-1:0]  out1_data;
  logic          out1_valid;
  logic          out1_ready;
  logic [1:0]    release_req;
  logic          active_bank;
  logic [1:0]    bank_full;
  logic          fill_done;
  logic [1:0]    word_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: bank fullness, pending output word per bank, block count.
  logic [1:0]   m_full;
  logic [1:0]   m_v;
  logic [W-1:0] m_d0;
  logic [W-1:0] m_d1;
  int unsigned  m_cnt;
  logic         m_act;
  logic         m_fd;
  logic         e_in_ready;
  logic         o_in_ready;

  // Words accepted per bank (in order) and words seen leaving each bank.
  logic [W-1:0] acc0[$];
  logic [W-1:0] acc1[$];
  logic [W-1:0] got0[$];
  logic [W-1:0] got1[$];

  always #5 clk = ~clk;

  pingpong_demux2 #(.WIDTH(W), .BLOCK_LEN(L)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out0_data   (out0_data),
    .out0_valid  (out0_valid),
    .out0_ready  (out0_ready),
    .out1_data   (out1_data),
    .out1_valid  (out1_valid),
    .out1_ready  (out1_ready),
    .release_req (release_req),
    .active_bank (active_bank),
    .bank_full   (bank_full),
    .fill_done   (fill_done),
    .word_cnt    (word_cnt)
  );

  function automatic bit same_words(input logic [W-1:0] a[$], input logic [W-1:0] b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[k]) if (a[k] !== b[k]) return 1'b0;
    return 1'b1;
  endfunction

  // One clock: drive at negedge, sample pre-edge, advance model, return at next negedge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic r0, input logic r1,
                      input logic [1:0] rel, input logic rs);
    logic [1:0] nv;
    logic [1:0] nf;
    in_valid    = v;
    in_data     = d;
    out0_ready  = r0;
    out1_ready  = r1;
    release_req = rel;
    rst         = rs;
    #1;
    e_in_ready = !rs && !m_full[m_act] && (!m_v[m_act] || (m_act ? r1 : r0));
    o_in_ready = in_ready;
    if (out0_valid && out0_ready) got0.push_back(out0_data);
    if (out1_valid && out1_ready) got1.push_back(out1_data);
    @(posedge clk);
    if (rs) begin
      m_full = 2'b00; m_v = 2'b00; m_d0 = '0; m_d1 = '0;
      m_cnt = 0; m_act = 1'b0; m_fd = 1'b0;
      acc0.delete(); acc1.delete(); got0.delete(); got1.delete();
    end else begin
      nv = m_v;
      nf = m_full;
      if (m_v[0] && r0) nv[0] = 1'b0;
      if (m_v[1] && r1) nv[1] = 1'b0;
      for (int b = 0; b < 2; b++)
        if (m_full[b] && rel[b] && !m_v[b]) nf[b] = 1'b0;
      m_fd = 1'b0;
      if (v && e_in_ready) begin
        nv[m_act] = 1'b1;
        if (m_act == 1'b0) begin m_d0 = d; acc0.push_back(d); end
        else begin m_d1 = d; acc1.push_back(d); end
        if (m_cnt == L - 1) begin
          nf[m_act] = 1'b1; m_cnt = 0; m_act = ~m_act; m_fd = 1'b1;
        end else begin
          m_cnt++;
        end
      end
      m_v = nv;
      m_full = nf;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    step(1'b1, 16'hFFFF, 1'b1, 1'b1, 2'b11, 1'b1);
    checks++;
    if (o_in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready got %b want 0", o_in_ready);
    end
    checks++;
    if ({out0_valid, out1_valid, out0_data, out1_data, active_bank, bank_full, fill_done, word_cnt} !== 40'h0) begin
      errors++;
      $display("FAIL reset_outputs got v0=%b v1=%b d0=%h d1=%h act=%b full=%b fd=%b cnt=%0d want all zero",
               out0_valid, out1_valid, out0_data, out1_data, active_bank, bank_full, fill_done, word_cnt);
    end
  endtask

  task automatic test_streaming();
    int fd_seen = 0;
    logic [W-1:0] w;
    step(1'b0, '0, 1'b1, 1'b1, 2'b00, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      w = 16'(i);
      step(1'b1, w, 1'b1, 1'b1, 2'b00, 1'b0);
      fd_seen += int'(fill_done);
      checks++;
      if (o_in_ready !== 1'b1) begin
        errors++; $display("FAIL stream_in_ready word %0d got %b want 1", i, o_in_ready);
      end
      checks++;
      if (i <= 4) begin
        if ({out0_valid, out0_data} !== {1'b1, w}) begin
          errors++; $display("FAIL stream_out0 got v=%b d=%h want v=1 d=%h", out0_valid, out0_data, w);
        end
      end else begin
        if ({out1_valid, out1_data} !== {1'b1, w}) begin
          errors++; $display("FAIL stream_out1 got v=%b d=%h want v=1 d=%h", out1_valid, out1_data, w);
        end
      end
      checks++;
      if ({active_bank, word_cnt} !== {1'((i / 4) % 2), 2'(i % 4)}) begin
        errors++; $display("FAIL stream_count word %0d got act=%b cnt=%0d want act=%0d cnt=%0d",
                           i, active_bank, word_cnt, (i / 4) % 2, i % 4);
      end
    end
    step(1'b0, '0, 1'b1, 1'b1, 2'b00, 1'b0);
    fd_seen += int'(fill_done);
    checks++;
    if (fd_seen != 2) begin
      errors++; $display("FAIL stream_fill_done got %0d pulses want 2", fd_seen);
    end
    checks++;
    if (bank_full !== 2'b11) begin
      errors++; $display("FAIL stream_bank_full got %b want 11", bank_full);
    end
    checks++;
    if (got0.size() != 4 || got1.size() != 4 ||
        got0[0] !== 16'd1 || got0[3] !== 16'd4 || got1[0] !== 16'd5 || got1[3] !== 16'd8) begin
      errors++; $display("FAIL stream_order got %0d/%0d words want 4/4 in order 1..4, 5..8",
                         got0.size(), got1.size());
    end
  endtask

  // Continues from the streaming state: both banks FULL.
  task automatic test_full_stall();
    step(1'b1, 16'h0009, 1'b1, 1'b1, 2'b00, 1'b0);
    checks++;
    if (o_in_ready !== 1'b0) begin
      errors++; $display("FAIL stall_in_ready got %b want 0", o_in_ready);
    end
    step(1'b1, 16'h0009, 1'b1, 1'b1, 2'b01, 1'b0);
    checks++;
    if (o_in_ready !== 1'b0 || bank_full !== 2'b10) begin
      errors++; $display("FAIL stall_release got rdy=%b full=%b want rdy=0 full=10", o_in_ready, bank_full);
    end
    step(1'b1, 16'h0009, 1'b1, 1'b1, 2'b00, 1'b0);
    checks++;
    if (o_in_ready !== 1'b1) begin
      errors++; $display("FAIL stall_accept got %b want 1", o_in_ready);
    end
    checks++;
    if ({out0_valid, out0_data, active_bank, word_cnt, bank_full} !== {1'b1, 16'h0009, 1'b0, 2'd1, 2'b10}) begin
      errors++; $display("FAIL stall_out0 got v=%b d=%h act=%b cnt=%0d full=%b want 1 0009 0 1 10",
                         out0_valid, out0_data, active_bank, word_cnt, bank_full);
    end
  endtask

  task automatic test_backpressure();
    int nxt = 1;
    logic [W-1:0] want[$];
    step(1'b0, '0, 1'b1, 1'b1, 2'b00, 1'b1);
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 16'(nxt), 1'b0, 1'b1, 2'b00, 1'b0);
      checks++;
      if (o_in_ready !== (c == 0)) begin
        errors++; $display("FAIL bp_in_ready cycle %0d got %b want %0d", c, o_in_ready, c == 0);
      end
      if (o_in_ready) nxt++;
      checks++;
      if ({out0_valid, out0_data} !== {1'b1, 16'h0001}) begin
        errors++; $display("FAIL bp_hold cycle %0d got v=%b d=%h want v=1 d=0001", c, out0_valid, out0_data);
      end
    end
    for (int c = 0; c < 20 && nxt <= 4; c++) begin
      step(1'b1, 16'(nxt), 1'b1, 1'b1, 2'b00, 1'b0);
      if (o_in_ready) nxt++;
    end
    checks++;
    if (nxt != 5) begin
      errors++; $display("FAIL bp_timeout got %0d words accepted want 4", nxt - 1);
    end
    step(1'b0, '0, 1'b1, 1'b1, 2'b00, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1, 2'b00, 1'b0);
    for (int k = 1; k <= 4; k++) want.push_back(16'(k));
    checks++;
    if (!same_words(got0, want)) begin
      errors++; $display("FAIL bp_words got %0d words (first %h) want 0001..0004", got0.size(),
                         got0.size() > 0 ? got0[0] : 16'h0);
    end
  endtask

  task automatic test_ignored_release();
    step(1'b0, '0, 1'b1, 1'b1, 2'b00, 1'b1);
    for (int i = 1; i <= 4; i++) step(1'b1, 16'(i), 1'b1, 1'b1, 2'b00, 1'b0);
    step(1'b1, 16'h0005, 1'b0, 1'b1, 2'b11, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 2'b11, 1'b0);
    checks++;
    if ({bank_full, active_bank, word_cnt, out0_valid, out0_data} !== {2'b01, 1'b1, 2'd1, 1'b1, 16'h0004}) begin
      errors++; $display("FAIL ign_release got full=%b act=%b cnt=%0d v0=%b d0=%h want 01 1 1 1 0004",
                         bank_full, active_bank, word_cnt, out0_valid, out0_data);
    end
    step(1'b0, '0, 1'b1, 1'b1, 2'b01, 1'b0);
    checks++;
    if ({out0_valid, bank_full} !== {1'b0, 2'b01}) begin
      errors++; $display("FAIL ign_drain got v0=%b full=%b want v0=0 full=01", out0_valid, bank_full);
    end
    step(1'b0, '0, 1'b1, 1'b1, 2'b01, 1'b0);
    checks++;
    if (bank_full !== 2'b00) begin
      errors++; $display("FAIL ign_rerelease got %b want 00", bank_full);
    end
  endtask

  task automatic test_simultaneous();
    step(1'b0, '0, 1'b1, 1'b1, 2'b00, 1'b1);
    for (int i = 1; i <= 3; i++) step(1'b1, 16'(i), 1'b1, 1'b1, 2'b00, 1'b0);
    step(1'b1, 16'h0004, 1'b1, 1'b1, 2'b01, 1'b0);
    checks++;
    if ({bank_full, active_bank, fill_done} !== {2'b01, 1'b1, 1'b1}) begin
      errors++; $display("FAIL simul got full=%b act=%b fd=%b want 01 1 1", bank_full, active_bank, fill_done);
    end
    step(1'b0, '0, 1'b1, 1'b1, 2'b00, 1'b0);
    checks++;
    if ({bank_full, fill_done} !== {2'b01, 1'b0}) begin
      errors++; $display("FAIL simul_after got full=%b fd=%b want 01 0", bank_full, fill_done);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b0, '0, 1'b1, 1'b1, 2'b00, 1'b1);
    step(1'b1, 16'h0001, 1'b0, 1'b1, 2'b00, 1'b0);
    step(1'b1, 16'h0002, 1'b1, 1'b1, 2'b00, 1'b0);
    checks++;
    if ({word_cnt, out0_valid, out0_data} !== {2'd2, 1'b1, 16'h0002}) begin
      errors++; $display("FAIL rstmid_pre got cnt=%0d v0=%b d0=%h want 2 1 0002", word_cnt, out0_valid, out0_data);
    end
    step(1'b0, '0, 1'b0, 1'b1, 2'b00, 1'b1);
    checks++;
    if ({word_cnt, out0_valid, active_bank, bank_full} !== {2'd0, 1'b0, 1'b0, 2'b00}) begin
      errors++; $display("FAIL rstmid_clear got cnt=%0d v0=%b act=%b full=%b want 0 0 0 00",
                         word_cnt, out0_valid, active_bank, bank_full);
    end
    step(1'b1, 16'h00AA, 1'b1, 1'b1, 2'b00, 1'b0);
    checks++;
    if ({o_in_ready, out0_valid, out0_data, word_cnt, active_bank} !== {1'b1, 1'b1, 16'h00AA, 2'd1, 1'b0}) begin
      errors++; $display("FAIL rstmid_refill got rdy=%b v0=%b d0=%h cnt=%0d act=%b want 1 1 00aa 1 0",
                         o_in_ready, out0_valid, out0_data, word_cnt, active_bank);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] d;
    logic [1:0]   rel;
    step(1'b0, '0, 1'b1, 1'b1, 2'b00, 1'b1);
    for (int c = 0; c < 400; c++) begin
      d   = 16'($urandom);
      rel = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      step($urandom_range(0, 3) != 0, d, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           rel, $urandom_range(0, 149) == 0);
      checks++;
      if (o_in_ready !== e_in_ready) begin
        errors++; $display("FAIL rand_in_ready cycle %0d got %b want %b", c, o_in_ready, e_in_ready);
      end
      checks++;
      if ({active_bank, word_cnt, bank_full, fill_done, out1_valid, out0_valid,
           m_v[0] ? out0_data : 16'h0, m_v[1] ? out1_data : 16'h0} !==
          {m_act, 2'(m_cnt), m_full, m_fd, m_v, m_v[0] ? m_d0 : 16'h0, m_v[1] ? m_d1 : 16'h0}) begin
        errors++;
        $display("FAIL rand_state cycle %0d got act=%b cnt=%0d full=%b fd=%b v=%b%b d0=%h d1=%h want act=%b cnt=%0d full=%b fd=%b v=%b d0=%h d1=%h",
                 c, active_bank, word_cnt, bank_full, fill_done, out1_valid, out0_valid, out0_data, out1_data,
                 m_act, m_cnt, m_full, m_fd, m_v, m_d0, m_d1);
      end
    end
    for (int c = 0; c < 3; c++) step(1'b0, '0, 1'b1, 1'b1, 2'b00, 1'b0);
    checks++;
    if (!same_words(got0, acc0) || !same_words(got1, acc1)) begin
      errors++; $display("FAIL rand_words got %0d/%0d words out want %0d/%0d in matching order",
                         got0.size(), got1.size(), acc0.size(), acc1.size());
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    out0_ready = 1'b1; out1_ready = 1'b1; release_req = 2'b00;
    m_full = 2'b00; m_v = 2'b00; m_d0 = '0; m_d1 = '0;
    m_cnt = 0; m_act = 1'b0; m_fd = 1'b0;
    e_in_ready = 1'b0; o_in_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_streaming();
    test_full_stall();
    test_backpressure();
    test_ignored_release();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pingpong_demux2.md
# pingpong_demux2

Write-side ping-pong demultiplexer for the accelerator's double-buffered operand and partial-sum banks. It steers a single valid/ready input word stream into one of two bank-write channels, filling bank 0 with BLOCK_LEN words, then bank 1, then back to bank 0. Before refilling a bank, it waits for that bank's consumer to release it. It is the producer-side counterpart of the 2:1 bank-select mux on the read side, and its `active_bank` output tells the reader which bank is being filled.

## Interface
- WIDTH, 16, data word width
- BLOCK_LEN, 16, words written per bank before switching (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  reset; synchronous, active-high
- in_data  input  WIDTH  incoming word
- in_valid  input  1  in_data valid
- in_ready  output  1  word accepted when in_valid && in_ready
- out0_data / out1_data  output  WIDTH  bank-write data
- out0_valid / out1_valid  output  1  bank-write data valid
- out0_ready / out1_ready  input  1  bank accepts the word
- release  input  2  release[b] frees full bank b (consumer finished reading)
- active_bank  output  1  bank currently being filled
- bank_full  output  2  bank_full[b] = bank b is in FULL state
- fill_done  output  1  one-cycle pulse on the cycle after a bank's last word is accepted
- word_cnt  output  $clog2(BLOCK_LEN)  words accepted into the active bank so far

## Operation
- Each bank b has a state machine with three states: FREE, FILL, FULL.
  - FREE→FILL on the first accepted word into bank b.
  - FILL→FULL when the BLOCK_LEN-th word is accepted.
  - FULL→FREE when release[b]=1 and outb_valid=0.
  - Otherwise, release[b] has no effect and is not latched (ignored in FREE/FILL, or while outb_valid=1).
- in_ready = (state[active_bank] != FULL) && (!outA_valid || outA_ready), where A = active_bank.
- On accept:
  - in_data is registered into outA_data, and outA_valid is set.
  - word_cnt increments.
  - On the BLOCK_LEN-th word: word_cnt returns to 0, active_bank toggles, state[A]=FULL, and fill_done pulses.
- outb_valid stays high until outb_ready is seen, and outb_data is held stable while valid. Simultaneous drain and refill of the same bank in one cycle is allowed (valid stays 1, data is replaced).
- The other bank's output register keeps draining independently while the active bank fills.
- Both banks FULL: in_ready=0 until a release is honored. Releasing a non-active FULL bank does not change active_bank.
- Release and last-word-accept for the same bank in the same cycle: the release is ignored, because the state was not yet FULL.
- Reset values (all outputs cleared):
  - in_ready=0 during reset
  - out*_valid=0, out*_data=0
  - active_bank=0, bank_full=2'b00, fill_done=0, word_cnt=0
  - both states FREE
- Reset mid-block discards the partial fill and any pending output words.

## Timing
- Latency: a word accepted in cycle N appears on outA_data/outA_valid in cycle N+1.
- Throughput: 1 word/cycle while the target bank is not FULL and its consumer holds ready=1.
- in_ready is combinational from state, active_bank, outA_valid and outA_ready. There is no path from in_valid to in_ready.
- The bank switch takes zero bubbles: a word offered in the cycle after the BLOCK_LEN-th accept goes to the other bank if that bank is FREE.
- Release is honored in cycle N (state FREE in N+1), so the first accept into that bank can occur in N+1.
- fill_done, bank_full and word_cnt are registered.

## Structure
- Shared package/header `pingpong_pkg` holds:
  - bank state encodings (FREE=2'd0, FILL=2'd1, FULL=2'd2)
  - a counter-width helper constant for BLOCK_LEN
- One natural sub-module, `bank_out_stage`, instantiated twice. It holds a one-entry registered output stage: data/valid registers with a load/drain interface, and exposes an `empty` flag.
- The state machines, the counter and the active_bank toggle live in the top level.

## Test plan
All cases use BLOCK_LEN=4, WIDTH=16.
- Streaming:
  - Stimulus: 8 consecutive words 0x0001..0x0008, both readys=1.
  - Required: 1..4 on out0 in cycles 2..5 and 5..8 on out1 in cycles 6..9; fill_done pulses twice; bank_full=2'b11 at end.
- Full stall:
  - Stimulus: after the streaming case, offer word 0x0009.
  - Required: in_ready=0. Pulse release[0] → bank_full[0] clears next cycle, 0x0009 is accepted the following cycle, and it appears on out0.
- Backpressure:
  - Stimulus: out0_ready=0 while writing bank 0.
  - Required: in_ready drops after the first accept; out0_data holds 0x0001 until ready rises; no words are lost or duplicated.
- Ignored release:
  - Stimulus: release[1] while bank 1 is FILL, and release[0] while bank 0 is FULL with out0_valid=1.
  - Required: no state change in either case; release[0] re-asserted after the drain frees bank 0.
- Simultaneous events:
  - Stimulus: 4th word into bank 0 accepted in the same cycle as release[0].
  - Required: bank 0 ends FULL, active_bank=1, fill_done=1.
- Reset:
  - Stimulus: assert rst after 2 of 4 words.
  - Required: next cycle word_cnt=0, out0_valid=0, active_bank=0, bank_full=0; refill restarts at bank 0 with count 0.
